// File: rtl/hard_mem_arb_pkg.sv
// Shared types for the 1RW hard-SRAM arbiter/sequencer: controller states and requester ids.
package hard_mem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic req_id_t;

  // Only one grant bit can be set, so the id is simply the upper bit.
  function automatic req_id_t grant_id(input logic [NUM_REQ-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/hard_mem_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer remembers the last winner.
module hard_mem_rr_arb2
  import hard_mem_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] v,
  input  logic               yumi,
  output logic [NUM_REQ-1:0] grant
);

  req_id_t ptr_q;

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant = '0;
    case (v)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr_q == 1'b1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ptr_q <= 1'b0;
    end else if (yumi) begin
      ptr_q <= grant_id(grant);
    end
  end

endmodule

// File: rtl/hard_mem_1rw_arb_ctrl.sv
// Sequencer/arbiter for a 1RW SRAM macro: zero-fill after reset, then round-robin
// sharing between two requesters with a 1-cycle tagged read response.
module hard_mem_1rw_arb_ctrl
  import hard_mem_arb_pkg::*;
#(
  parameter  int ELS    = 512,
  parameter  int WIDTH  = 64,
  localparam int ADDR_W = $clog2(ELS)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  output logic                      init_done_o,
  input  logic [NUM_REQ-1:0]        req_v_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_w_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ*WIDTH-1:0]  req_mask_i,
  output logic [NUM_REQ-1:0]        rd_v_o,
  output logic [WIDTH-1:0]          rd_data_o,
  output logic                      mem_v_o,
  output logic                      mem_w_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]          mem_data_o,
  output logic [WIDTH-1:0]          mem_w_mask_o,
  input  logic [WIDTH-1:0]          mem_data_i
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    init_cnt_q;
  logic                 init_last;
  logic [NUM_REQ-1:0]   arb_v;
  logic [NUM_REQ-1:0]   grant;
  req_id_t              gid;
  logic [NUM_REQ-1:0]   rd_v_p1;

  assign init_last = (init_cnt_q == ADDR_W'(ELS - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_last) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      init_cnt_q <= '0;
    end else if (state_q == INIT) begin
      init_cnt_q <= init_last ? '0 : init_cnt_q + ADDR_W'(1);
    end
  end

  // Requests are masked during the fill so they wait rather than get lost.
  assign arb_v = (state_q == RUN) ? req_v_i : '0;

  hard_mem_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v       (arb_v),
    .yumi    (|grant),
    .grant   (grant)
  );

  assign gid         = grant_id(grant);
  assign req_ready_o = grant;
  assign init_done_o = (state_q == RUN);

  // Macro drive; held at zero while reset is asserted even though the state reads INIT.
  always_comb begin
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;
    if (reset_i) begin
      if (state_q == INIT) begin
        mem_v_o      = 1'b1;
        mem_w_o      = 1'b1;
        mem_addr_o   = init_cnt_q;
        mem_w_mask_o = '1;
      end else if (|grant) begin
        mem_v_o    = 1'b1;
        mem_w_o    = req_w_i[gid];
        mem_addr_o = gid ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
        mem_data_o = gid ? req_data_i[WIDTH +: WIDTH]   : req_data_i[0 +: WIDTH];
        if (req_w_i[gid]) begin
          mem_w_mask_o = gid ? req_mask_i[WIDTH +: WIDTH] : req_mask_i[0 +: WIDTH];
        end
      end
    end
  end

  // ---- stage p1: macro read data returns, tagged with the requester that issued it ----
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_v_p1 <= '0;
    end else begin
      rd_v_p1 <= grant & ~req_w_i;
    end
  end

  assign rd_v_o    = rd_v_p1;
  assign rd_data_o = mem_data_i;

endmodule

// File: tb/tb_hard_mem_1rw_arb_ctrl.sv
// Directed bench for hard_mem_1rw_arb_ctrl with a behavioural 1RW macro attached.
module tb_hard_mem_1rw_arb_ctrl;

  localparam int ELS   = 512;
  localparam int WIDTH = 64;
  localparam int AW    = 9;

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic                 init_done;
  logic [1:0]           req_v, req_ready, req_w, rd_v;
  logic [2*AW-1:0]      req_addr;
  logic [2*WIDTH-1:0]   req_data, req_mask;
  logic [WIDTH-1:0]     rd_data;
  logic                 mem_v, mem_w;
  logic [AW-1:0]        mem_addr;
  logic [WIDTH-1:0]     mem_data, mem_mask, mem_rdata;
  logic [WIDTH-1:0]     mem [ELS];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hard_mem_1rw_arb_ctrl #(.ELS(ELS), .WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .init_done_o  (init_done),
    .req_v_i      (req_v),
    .req_ready_o  (req_ready),
    .req_w_i      (req_w),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_mask_i   (req_mask),
    .rd_v_o       (rd_v),
    .rd_data_o    (rd_data),
    .mem_v_o      (mem_v),
    .mem_w_o      (mem_w),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .mem_w_mask_o (mem_mask),
    .mem_data_i   (mem_rdata)
  );

  // Macro model: read data appears the cycle after the access, read happens before write.
  always @(posedge clk) begin
    if (mem_v) begin
      if (mem_w) mem[mem_addr] <= (mem[mem_addr] & ~mem_mask) | (mem_data & mem_mask);
      else       mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic w, input logic [AW-1:0] a,
                     input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    req_v[k]                   = 1'b1;
    req_w[k]                   = w;
    req_addr[k*AW +: AW]       = a;
    req_data[k*WIDTH +: WIDTH] = d;
    req_mask[k*WIDTH +: WIDTH] = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g [6];
    logic [1:0] prev;
    int         n;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    // 1: reset, then the zero-fill pass with both requesters waiting
    reset_i = 1'b0;
    req_v = '0; req_w = '0; req_addr = '0; req_data = '0; req_mask = '0;
    put(0, 1'b0, 0, 0, 0);
    put(1, 1'b0, 0, 0, 0);
    #2;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_mem_v", mem_v, 1'b0);
    chk("rst_mem_w", mem_w, 1'b0);
    chk("rst_mask", mem_mask, 0);
    chk("rst_done", init_done, 1'b0);
    chk("rst_rd_v", rd_v, 2'b00);
    repeat (3) next();
    reset_i = 1'b1;
    #1;
    for (int i = 0; i < ELS; i++) begin
      chk("init_addr", mem_addr, i);
      chk("init_ctl", {req_ready, mem_v, mem_w, init_done, mem_data == 0, mem_mask == '1},
          {2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
      next();
      #1;
    end
    chk("init_done", init_done, 1'b1);
    chk("first_grant", req_ready, 2'b10);
    next(); req_v = '0; #1;
    chk("first_rd_v", rd_v, 2'b10);
    chk("first_rd_data", rd_data, 0);

    // 2: p0 reads addr 5
    next(); req_v = '0; put(0, 1'b0, 5, 0, 0); #1;
    chk("t2_ready", req_ready, 2'b01);
    chk("t2_mem_v", mem_v, 1'b1);
    chk("t2_mem_w", mem_w, 1'b0);
    chk("t2_addr", mem_addr, 5);
    chk("t2_mask", mem_mask, 0);
    next(); req_v = '0; #1;
    chk("t2_rd_v", rd_v, 2'b01);
    chk("t2_rd_data", rd_data, 0);

    // 3: p1 masked write then read-back of addr 7
    next(); req_v = '0; put(1, 1'b1, 7, 64'hDEAD_BEEF, 64'h0000_FFFF); #1;
    chk("t3_ready_w", req_ready, 2'b10);
    chk("t3_mem_w", mem_w, 1'b1);
    chk("t3_addr", mem_addr, 7);
    chk("t3_data", mem_data, 64'hDEAD_BEEF);
    chk("t3_mask", mem_mask, 64'h0000_FFFF);
    next(); req_v = '0; put(1, 1'b0, 7, 0, 0); #1;
    chk("t3_no_wr_resp", rd_v, 2'b00);
    chk("t3_ready_r", req_ready, 2'b10);
    next(); req_v = '0; #1;
    chk("t3_rd_v", rd_v, 2'b10);
    chk("t3_rd_data", rd_data, 64'h0000_BEEF);

    // 4: both requesters read continuously
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      next(); req_v = '0; put(0, 1'b0, 5, 0, 0); put(1, 1'b0, 7, 0, 0); #1;
      chk("t4_grant", req_ready, exp_g[i]);
      chk("t4_rd_v", rd_v, prev);
      if (prev == 2'b10) chk("t4_rd_p1", rd_data, 64'h0000_BEEF);
      if (prev == 2'b01) chk("t4_rd_p0", rd_data, 0);
      prev = exp_g[i];
    end
    next(); req_v = '0; #1;
    chk("t4_last_rd_v", rd_v, 2'b10);
    chk("t4_last_rd", rd_data, 64'h0000_BEEF);

    // 6: read then write of addr 3 back to back
    next(); req_v = '0; put(0, 1'b1, 3, 64'h11, '1); #1;
    chk("t6_w1_ready", req_ready, 2'b01);
    next(); req_v = '0; put(0, 1'b0, 3, 0, 0); #1;
    chk("t6_r_ready", req_ready, 2'b01);
    next(); req_v = '0; put(1, 1'b1, 3, 64'h22, '1); #1;
    chk("t6_w2_ready", req_ready, 2'b10);
    chk("t6_old_rd_v", rd_v, 2'b01);
    chk("t6_old_data", rd_data, 64'h11);
    next(); req_v = '0; put(0, 1'b0, 3, 0, 0); #1;
    chk("t6_w_no_resp", rd_v, 2'b00);
    chk("t6_r2_ready", req_ready, 2'b01);
    next(); req_v = '0; #1;
    chk("t6_new_rd_v", rd_v, 2'b01);
    chk("t6_new_data", rd_data, 64'h22);

    // 5: reset lands in the cycle of a p0 read grant
    next(); req_v = '0; put(0, 1'b0, 5, 0, 0); #1;
    chk("t5_ready", req_ready, 2'b01);
    reset_i = 1'b0;
    #1;
    chk("t5_rst_ready", req_ready, 2'b00);
    chk("t5_rst_mem_v", mem_v, 1'b0);
    next(); #1;
    chk("t5_rd_v_drop", rd_v, 2'b00);
    chk("t5_done_low", init_done, 1'b0);
    next(); req_v = '0; reset_i = 1'b1; #1;
    chk("t5_rd_v_drop2", rd_v, 2'b00);
    chk("t5_reinit_addr", mem_addr, 0);
    chk("t5_reinit_ctl", {mem_v, mem_w, init_done}, 3'b110);
    next(); #1;
    chk("t5_reinit_addr1", mem_addr, 1);
    n = 1;
    while (!init_done && n < 600) begin
      next(); #1;
      n++;
    end
    chk("t5_init_cycles", n, ELS);
    next(); req_v = '0; put(0, 1'b0, 3, 0, 0); #1;
    chk("t5_post_ready", req_ready, 2'b01);
    next(); req_v = '0; #1;
    chk("t5_post_rd_v", rd_v, 2'b01);
    chk("t5_post_zero", rd_data, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
